// File: rtl/fetch_seq.sv
// fetch_seq: 12-phase machine-cycle sequencer fetching up to two code bytes per
// cycle (slot 1 in S1-S3, slot 2 in S4-S6) from internal ROM or the external P0/P2 bus.
module fetch_seq #(
    parameter int CYCLE_LEN = 12,
    parameter int EXT_DLY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EA,
    input  logic        run,
    input  logic        fetch1_en,
    input  logic        fetch2_en,
    input  logic [15:0] PC,
    input  logic [7:0]  code_din,
    input  logic [7:0]  P0_in,
    output logic        ALE,
    output logic        PSEN,
    output logic        CODE_CS,
    output logic [7:0]  P0_out,
    output logic [7:0]  P2_out,
    output logic        P0_oe,
    output logic        P2_oe,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        byte_slot,
    output logic        PC_inc,
    output logic [3:0]  phase,
    output logic        cycle_start
);
    localparam logic [3:0] LAST_PHASE = 4'(CYCLE_LEN - 1);
    localparam logic [3:0] SLOT_LEN   = 4'(CYCLE_LEN / 2);
    localparam logic [3:0] ADDR_END   = 4'(2 + EXT_DLY);

    logic [3:0] phase_q;
    logic [3:0] phase_next;
    logic       ea_q;
    logic       f1_q;
    logic       f2_q;
    logic       slot2;
    logic [3:0] offset;
    logic       slot_req;
    logic       ext_fetch;
    logic       int_fetch;
    logic       strobe;
    logic       capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_next;
        end
    end

    // Phase 0 is the only place the sequencer may park; a started cycle always completes.
    always_comb begin
        phase_next = phase_q;
        if (phase_q == LAST_PHASE) begin
            phase_next = '0;
        end else if (phase_q != 4'd0 || run) begin
            phase_next = phase_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ea_q <= 1'b0;
            f1_q <= 1'b0;
            f2_q <= 1'b0;
        end else begin
            if (phase_q == 4'd0 && run) begin
                ea_q <= EA;
                f1_q <= fetch1_en;
            end
            if (phase_q == SLOT_LEN) begin
                f2_q <= fetch2_en;
            end
        end
    end

    // Both slots share one timing template; offset is the position inside the current slot.
    always_comb begin
        slot2     = (phase_q >= SLOT_LEN);
        offset    = slot2 ? (phase_q - SLOT_LEN) : phase_q;
        slot_req  = slot2 ? f2_q : f1_q;
        ext_fetch = slot_req && !ea_q;
        int_fetch = slot_req && ea_q;
        strobe    = (offset >= 4'd4);
        capture   = slot_req && (offset == SLOT_LEN - 4'd1);
    end

    assign ALE         = (offset == 4'd1) || (offset == 4'd2);
    assign P2_oe       = ext_fetch && (offset != 4'd0);
    assign P0_oe       = ext_fetch && (offset != 4'd0) && (offset <= ADDR_END);
    assign PSEN        = !(ext_fetch && strobe);
    assign CODE_CS     = int_fetch && strobe;
    assign P0_out      = P0_oe ? PC[7:0] : 8'h00;
    assign P2_out      = P2_oe ? PC[15:8] : 8'h00;
    assign phase       = phase_q;
    assign cycle_start = (phase_q == 4'd0) && run;

    // byte_valid/PC_inc are one-clk strobes with no ready: the consumer takes
    // byte_out/byte_slot on the clk they are flagged, and byte_out holds until the next fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            byte_slot  <= 1'b0;
            PC_inc     <= 1'b0;
        end else begin
            byte_valid <= capture;
            PC_inc     <= capture;
            if (capture) begin
                byte_out  <= ea_q ? code_din : P0_in;
                byte_slot <= slot2;
            end
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed vector table, hand-written corner sequences, then random
// stimulus checked against a phase-level reference model with a byte scoreboard.
module tb_fetch_seq;
    localparam int EXT_DLY = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        EA;
    logic        run;
    logic        fetch1_en;
    logic        fetch2_en;
    logic [15:0] PC;
    logic [7:0]  code_din;
    logic [7:0]  P0_in;
    logic        ALE;
    logic        PSEN;
    logic        CODE_CS;
    logic [7:0]  P0_out;
    logic [7:0]  P2_out;
    logic        P0_oe;
    logic        P2_oe;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_slot;
    logic        PC_inc;
    logic [3:0]  phase;
    logic        cycle_start;

    logic [7:0]  rom [256];
    int          checks   = 0;
    int          failures = 0;

    fetch_seq #(.CYCLE_LEN(12), .EXT_DLY(EXT_DLY)) dut (
        .clk(clk), .reset(reset), .EA(EA), .run(run),
        .fetch1_en(fetch1_en), .fetch2_en(fetch2_en), .PC(PC),
        .code_din(code_din), .P0_in(P0_in), .ALE(ALE), .PSEN(PSEN),
        .CODE_CS(CODE_CS), .P0_out(P0_out), .P2_out(P2_out),
        .P0_oe(P0_oe), .P2_oe(P2_oe), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_slot(byte_slot), .PC_inc(PC_inc),
        .phase(phase), .cycle_start(cycle_start)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    assign code_din = rom[PC[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: the environment's PC register follows PC_inc like the CPU would.
    task automatic tick(input bit use_model);
        logic inc;
        inc = PC_inc;
        if (use_model) model_edge();
        @(posedge clk);
        #1;
        if (inc) PC = PC + 16'd1;
        #1;
    endtask

    // ---------------- reference model + scoreboard ----------------
    int         m_phase;
    bit         m_ea;
    bit         m_req [2];
    bit         m_pulse;
    logic [8:0] exp_q [$];

    function automatic void model_edge();
        int slot;
        slot    = m_phase / 6;
        m_pulse = 1'b0;
        if (m_phase % 6 == 5 && m_req[slot]) begin
            exp_q.push_back({1'(slot), (m_ea ? rom[PC[7:0]] : P0_in)});
            m_pulse = 1'b1;
        end
        if (m_phase == 0 && run) begin
            m_ea     = EA;
            m_req[0] = fetch1_en;
        end
        if (m_phase == 6) m_req[1] = fetch2_en;
        if (m_phase != 0 || run) m_phase = (m_phase + 1) % 12;
    endfunction

    task automatic model_check();
        int         off;
        bit         req;
        bit         ext;
        bit         p0_en;
        bit         p2_en;
        logic [8:0] e;
        off   = m_phase % 6;
        req   = m_req[m_phase / 6];
        ext   = req && !m_ea;
        p0_en = ext && off >= 1 && off <= 2 + EXT_DLY;
        p2_en = ext && off >= 1;
        chk("rnd_phase", phase, m_phase);
        chk("rnd_ale", ALE, (off == 1 || off == 2));
        chk("rnd_psen", PSEN, !(ext && off >= 4));
        chk("rnd_code_cs", CODE_CS, (req && m_ea && off >= 4));
        chk("rnd_p0_oe", P0_oe, p0_en);
        chk("rnd_p2_oe", P2_oe, p2_en);
        chk("rnd_p0_out", P0_out, p0_en ? PC[7:0] : 8'h00);
        chk("rnd_p2_out", P2_out, p2_en ? PC[15:8] : 8'h00);
        chk("rnd_byte_valid", byte_valid, m_pulse);
        chk("rnd_pc_inc", PC_inc, m_pulse);
        chk("rnd_cycle_start", cycle_start, (m_phase == 0 && run));
        if (m_pulse && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rnd_byte_out", byte_out, e[7:0]);
            chk("rnd_byte_slot", byte_slot, e[8]);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        ea;
        logic        f1;
        logic        f2;
        logic [15:0] pc;
        logic [7:0]  p0;
        int          nvalid;
        logic [7:0]  b1;
        logic        b1_slot;
        logic [7:0]  b2;
        logic [15:0] pc_end;
        int          n_ale;
        int          n_psen;
        int          n_cs;
        int          n_p0oe;
        int          n_p2oe;
        logic [7:0]  p0_ph1;
        logic [7:0]  p2_ph1;
        logic [7:0]  p0_ph7;
        logic [7:0]  p2_ph7;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int idx, input vec_t v);
        int nv;
        int n_ale;
        int n_psen;
        int n_cs;
        int n_p0oe;
        int n_p2oe;
        nv = 0; n_ale = 0; n_psen = 0; n_cs = 0; n_p0oe = 0; n_p2oe = 0;
        EA = v.ea; fetch1_en = v.f1; fetch2_en = v.f2; PC = v.pc; P0_in = v.p0; run = 1'b1;
        #1;
        chk($sformatf("v%0d_start_phase", idx), phase, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0);
            chk($sformatf("v%0d_phase", idx), phase, k % 12);
            n_ale  += int'(ALE);
            n_psen += int'(!PSEN);
            n_cs   += int'(CODE_CS);
            n_p0oe += int'(P0_oe);
            n_p2oe += int'(P2_oe);
            if (k == 1) begin
                chk($sformatf("v%0d_p0_ph1", idx), P0_out, v.p0_ph1);
                chk($sformatf("v%0d_p2_ph1", idx), P2_out, v.p2_ph1);
            end
            if (k == 7) begin
                chk($sformatf("v%0d_p0_ph7", idx), P0_out, v.p0_ph7);
                chk($sformatf("v%0d_p2_ph7", idx), P2_out, v.p2_ph7);
            end
            if (byte_valid) begin
                nv++;
                chk($sformatf("v%0d_pc_inc", idx), PC_inc, 1);
                if (nv == 1) begin
                    chk($sformatf("v%0d_b1", idx), byte_out, v.b1);
                    chk($sformatf("v%0d_b1_slot", idx), byte_slot, v.b1_slot);
                end else begin
                    chk($sformatf("v%0d_b2", idx), byte_out, v.b2);
                    chk($sformatf("v%0d_b2_slot", idx), byte_slot, 1);
                end
            end
        end
        run = 1'b0;
        tick(1'b0);
        chk($sformatf("v%0d_nvalid", idx), nv, v.nvalid);
        chk($sformatf("v%0d_n_ale", idx), n_ale, v.n_ale);
        chk($sformatf("v%0d_n_psen", idx), n_psen, v.n_psen);
        chk($sformatf("v%0d_n_cs", idx), n_cs, v.n_cs);
        chk($sformatf("v%0d_n_p0oe", idx), n_p0oe, v.n_p0oe);
        chk($sformatf("v%0d_n_p2oe", idx), n_p2oe, v.n_p2oe);
        chk($sformatf("v%0d_pc_end", idx), PC, v.pc_end);
        chk($sformatf("v%0d_idle_phase", idx), phase, 0);
        chk($sformatf("v%0d_idle_valid", idx), byte_valid, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nv;
        int n_cs_a;
        int n_ps_a;
        int n_cs_b;
        int n_ps_b;

        reset = 1'b0; run = 1'b1; EA = 1'b0; fetch1_en = 1'b1; fetch2_en = 1'b1;
        PC = 16'hFFFF; P0_in = 8'hFF;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
        rom[8'h10] = 8'h74; rom[8'h11] = 8'h55; rom[8'h20] = 8'h3C;
        rom[8'h40] = 8'h9A; rom[8'h41] = 8'h6B;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h0010, 8'h00, 2, 8'h74, 1'b0, 8'h55, 16'h0012,
                    4, 0, 4, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h1234, 8'hE4, 1, 8'hE4, 1'b0, 8'h00, 16'h1235,
                    4, 2, 0, 3, 5, 8'h34, 8'h12, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h00FF, 8'h5A, 2, 8'h5A, 1'b0, 8'h5A, 16'h0101,
                    4, 4, 0, 6, 10, 8'hFF, 8'h00, 8'h00, 8'h01};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0020, 8'h00, 1, 8'h3C, 1'b1, 8'h00, 16'h0021,
                    4, 0, 2, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0030, 8'h00, 0, 8'h00, 1'b0, 8'h00, 16'h0030,
                    4, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 16'hABCD, 8'h77, 0, 8'h00, 1'b0, 8'h00, 16'hABCD,
                    4, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h8001, 8'h0F, 1, 8'h0F, 1'b1, 8'h00, 16'h8002,
                    4, 2, 0, 3, 5, 8'h00, 8'h00, 8'h01, 8'h80};

        // reset state with busy-looking inputs applied
        #12;
        chk("rst_phase", phase, 0);
        chk("rst_ale", ALE, 0);
        chk("rst_psen", PSEN, 1);
        chk("rst_code_cs", CODE_CS, 0);
        chk("rst_p0_oe", P0_oe, 0);
        chk("rst_p2_oe", P2_oe, 0);
        chk("rst_p0_out", P0_out, 8'h00);
        chk("rst_p2_out", P2_out, 8'h00);
        chk("rst_byte_out", byte_out, 8'h00);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_pc_inc", PC_inc, 0);
        run = 1'b0; fetch1_en = 1'b0; fetch2_en = 1'b0;
        reset = 1'b1;
        tick(1'b0);
        chk("idle_phase", phase, 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // run dropped at phase 3: cycle and its fetches complete, then park at 0
        EA = 1'b1; fetch1_en = 1'b1; fetch2_en = 1'b1; PC = 16'h0010; run = 1'b1;
        nv = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0);
            if (k == 3) run = 1'b0;
            nv += int'(byte_valid);
            chk("h1_phase", phase, k % 12);
            chk("h1_ale", ALE, (k == 1 || k == 2 || k == 7 || k == 8));
        end
        chk("h1_nvalid", nv, 2);
        chk("h1_last_byte", byte_out, 8'h55);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0);
            chk("h1_park_phase", phase, 0);
            chk("h1_park_ale", ALE, 0);
            chk("h1_park_valid", byte_valid, 0);
            chk("h1_park_cycle_start", cycle_start, 0);
        end

        // reset asserted during the PSEN strobe of an external fetch
        EA = 1'b0; fetch1_en = 1'b1; fetch2_en = 1'b0; PC = 16'h1234; P0_in = 8'hC9; run = 1'b1;
        repeat (4) tick(1'b0);
        chk("h2_phase_pre", phase, 4);
        chk("h2_psen_pre", PSEN, 0);
        reset = 1'b0;
        #1;
        chk("h2_psen", PSEN, 1);
        chk("h2_p0_oe", P0_oe, 0);
        chk("h2_p2_oe", P2_oe, 0);
        chk("h2_phase", phase, 0);
        chk("h2_byte_out", byte_out, 8'h00);
        fetch1_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0);
            chk("h2_hold_phase", phase, 0);
            chk("h2_hold_valid", byte_valid, 0);
        end
        reset = 1'b1;
        nv = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0);
            chk("h2_restart_phase", phase, k % 12);
            nv += int'(byte_valid);
        end
        chk("h2_no_valid", nv, 0);
        run = 1'b0;
        tick(1'b0);

        // EA toggled at phase 3: old mode for the rest of this cycle only
        EA = 1'b1; fetch1_en = 1'b1; fetch2_en = 1'b1; PC = 16'h0040; P0_in = 8'h3E; run = 1'b1;
        nv = 0; n_cs_a = 0; n_ps_a = 0; n_cs_b = 0; n_ps_b = 0;
        for (int k = 1; k <= 24; k++) begin
            tick(1'b0);
            if (k == 3) EA = 1'b0;
            if (k <= 12) begin
                n_cs_a += int'(CODE_CS);
                n_ps_a += int'(!PSEN);
                if (byte_valid) begin
                    nv++;
                    chk("h3_byte", byte_out, (nv == 1) ? 8'h9A : 8'h6B);
                end
            end else begin
                n_cs_b += int'(CODE_CS);
                n_ps_b += int'(!PSEN);
            end
        end
        chk("h3_cs_old", n_cs_a, 4);
        chk("h3_psen_old", n_ps_a, 0);
        chk("h3_nvalid_old", nv, 2);
        chk("h3_cs_new", n_cs_b, 0);
        chk("h3_psen_new", n_ps_b, 4);
        run = 1'b0;
        tick(1'b0);

        // random stimulus against the reference model
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
        PC = 16'($urandom_range(0, 65535));
        m_phase = 0; m_ea = 1'b0; m_req[0] = 1'b0; m_req[1] = 1'b0; m_pulse = 1'b0;
        for (int n = 0; n < 800; n++) begin
            EA        = 1'($urandom_range(0, 1));
            fetch1_en = 1'($urandom_range(0, 1));
            fetch2_en = 1'($urandom_range(0, 1));
            run       = ($urandom_range(0, 7) != 0);
            P0_in     = 8'($urandom_range(0, 255));
            #1;
            model_check();
            tick(1'b1);
        end
        run = 1'b0;
        for (int n = 0; n < 14; n++) begin
            #1;
            model_check();
            tick(1'b1);
        end
        chk("rnd_final_phase", phase, 0);
        chk("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter CYCLE_LEN, default 12, clk periods per machine cycle; fixed, other values unsupported.
REQ-002 Parameter EXT_DLY, default 1, phases the P0 address is held after ALE falls.
REQ-003 clk  input  1  12MHz system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 EA  input  1  H internal code ROM, L external code ROM; sampled at phase 0.
REQ-006 run  input  1  H machine cycles advance; L sequencer parks at phase 0.
REQ-007 fetch1_en  input  1  CU request for a code byte in slot 1 (S1-S3); sampled at phase 0.
REQ-008 fetch2_en  input  1  CU request for a code byte in slot 2 (S4-S6); sampled at phase 6.
REQ-009 PC  input  16  current program counter from PCH/PCL.
REQ-010 code_din  input  8  internal code ROM data.
REQ-011 P0_in  input  8  external bus data pins.
REQ-012 ALE  output  1  address latch enable, active high.
REQ-013 PSEN  output  1  program store enable, active low.
REQ-014 CODE_CS  output  1  internal ROM chip select, active high.
REQ-015 P0_out, P2_out  output  8 each  low/high address drive.
REQ-016 P0_oe, P2_oe  output  1 each  port drive enables.
REQ-017 byte_out  output  8  fetched code byte, held until next fetch.
REQ-018 byte_valid  output  1  one-clk pulse: byte_out updated this cycle.
REQ-019 byte_slot  output  1  L slot 1, H slot 2; valid with byte_valid.
REQ-020 PC_inc  output  1  one-clk pulse, coincident with byte_valid, tells PC to increment.
REQ-021 phase  output  4  current phase 0..11 (S1P1=0 ... S6P2=11).
REQ-022 cycle_start  output  1  high while phase==0 and run==1.

Function
REQ-023 Phase counter SHALL count 0..11 and wrap 11->0 while run=1; when run=0 it SHALL finish the current cycle and hold at 0.
REQ-024 At phase 0 SHALL latch EA into ea_q and fetch1_en into f1_q; at phase 6 SHALL latch fetch2_en into f2_q; ea_q SHALL stay constant for the whole cycle.
REQ-025 ALE SHALL be high in phases 1,2 and 7,8 of every running cycle, regardless of fetch requests (dummy ALE).
REQ-026 External slot k (ea_q=0, request latched): P2_oe=1, P2_out=PC[15:8] for phases 1-5 (slot1) / 7-11 (slot2); P0_oe=1, P0_out=PC[7:0] for phases 1..2+EXT_DLY / 7..8+EXT_DLY, then P0_oe=0.
REQ-027 External fetch: PSEN=0 in phases 4,5 (slot1) / 10,11 (slot2); P0_in SHALL be captured on the rising edge ending phase 5 / 11.
REQ-028 Internal fetch (ea_q=1): CODE_CS=1 in phases 4,5 / 10,11; code_din captured on edge ending phase 5 / 11; PSEN, P0_oe, P2_oe SHALL stay inactive.
REQ-029 On each capture: byte_out loaded, byte_valid=1 and PC_inc=1 for exactly the following clk, byte_slot set; no capture and no pulse when the slot request was not latched.
REQ-030 Slot 2 SHALL use PC as present at phase 7, i.e. after the slot 1 PC_inc has taken effect.
REQ-031 fetch1_en/fetch2_en changes outside phases 0/6 SHALL have no effect.
REQ-032 run falling mid-cycle SHALL not abort in-progress fetches; that cycle completes normally.

Reset
REQ-033 reset=0 SHALL immediately force phase=0, ALE=0, PSEN=1, CODE_CS=0, P0_oe=0, P2_oe=0, P0_out=P2_out=8'h00, byte_out=8'h00, byte_valid=0, PC_inc=0, latched requests cleared.
REQ-034 Reset released mid-cycle SHALL restart at phase 0 on the first clk edge with run=1; no partial fetch is completed.

Verification
REQ-035 Internal: EA=1, run=1, fetch1_en=fetch2_en=1, PC=16'h0010, ROM[10]=8'h74, ROM[11]=8'h55 -> byte_valid at phase 0+6 and 0+12 boundaries with 8'h74 slot L, 8'h55 slot H; two PC_inc pulses; PSEN stays 1.
REQ-036 External: EA=0, PC=16'h1234, P0_in=8'hE4 during phase 5 -> ALE high phases 1,2; P0_out=8'h34 phases 1-3; P2_out=8'h12; PSEN low phases 4,5; byte_out=8'hE4.
REQ-037 Dummy: fetch2_en=0 at phase 6 -> ALE still high phases 7,8; no CODE_CS/PSEN; one PC_inc per cycle.
REQ-038 run dropped at phase 3 -> cycle completes to phase 11, then phase holds 0, ALE stays 0.
REQ-039 reset asserted at phase 4 with PSEN=0 -> PSEN=1, P0_oe=P2_oe=0 same time, no byte_valid; restarts phase 0 after release.
REQ-040 EA toggled at phase 3 -> current cycle keeps old mode; new mode from next phase 0.
